// File: rtl/dbus_to_cbus_wb_pkg.sv
// Shared DBus/CBus bundle types for the posted-write bridge.
// Also holds the write-buffer entry and CBus request builders.
package dbus_to_cbus_wb_pkg;

  typedef logic [3:0] axi_len_t;
  typedef logic [1:0] axi_burst_t;

  localparam axi_len_t   MLEN1           = 4'd0;
  localparam axi_burst_t AXI_BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    WDRAIN,
    READ,
    RESP
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    axi_len_t    len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } wb_entry_t;

  function automatic cbus_req_t wr_req(wb_entry_t e);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = 1'b1;
    r.size     = e.size;
    r.addr     = e.addr;
    r.strobe   = e.strobe;
    r.data     = e.data;
    r.len      = MLEN1;
    r.burst    = AXI_BURST_FIXED;
    return r;
  endfunction

  function automatic cbus_req_t rd_req(dbus_req_t d);
    cbus_req_t r;
    r       = '0;
    r.valid = 1'b1;
    r.size  = d.size;
    r.addr  = d.addr;
    r.len   = MLEN1;
    r.burst = AXI_BURST_FIXED;
    return r;
  endfunction

endpackage

// File: rtl/dbus_to_cbus_wb_fifo.sv
// Circular write buffer with head and head-after-pop lookahead.
// next_data forwards wr_data when the only entry is being replaced.
module dbus_to_cbus_wb_fifo
  import dbus_to_cbus_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  wb_entry_t              wr_data,
  output wb_entry_t              head_data,
  output wb_entry_t              next_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0] CNT_FULL = DEPTH[PW:0];

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   inc;
  logic [PW:0]   dec;

  assign inc = {{PW{1'b0}}, push};
  assign dec = {{PW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + inc - dec;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wr_data;
  end

  assign head_data = mem[head];
  assign next_data = (count == CNT_ONE) ? wr_data
                                        : mem[head + PW'(1)];
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

endmodule

// File: rtl/dbus_to_cbus_wb.sv
// DBus-to-CBus bridge: posted stores drain in order, loads wait
// for an empty buffer, CBus request fields are registered.
module dbus_to_cbus_wb
  import dbus_to_cbus_wb_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int REG_READ_DATA = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  dbus_req_t              dreq,
  output dbus_resp_t             dresp,
  output cbus_req_t              dcreq,
  input  cbus_resp_t             dcresp,
  output logic                   wb_empty,
  output logic [$clog2(DEPTH):0] wb_count
);
  localparam int PW = $clog2(DEPTH);

  state_t      state;
  state_t      state_n;
  cbus_req_t   req_q;
  cbus_req_t   req_n;
  logic [63:0] rdata_q;
  logic        is_wr;
  logic        push;
  logic        pop;
  logic        fire;
  logic        full;
  logic        empty;
  logic [PW:0] count;
  wb_entry_t   in_e;
  wb_entry_t   head_e;
  wb_entry_t   next_e;

  assign is_wr = |dreq.strobe;
  assign push  = dreq.valid & is_wr & ~full & ~reset;
  assign fire  = req_q.valid & dcresp.ready & dcresp.last;
  assign pop   = (state == WDRAIN) & fire;
  assign in_e  = '{dreq.addr, dreq.size, dreq.strobe, dreq.data};

  dbus_to_cbus_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .wr_data  (in_e),
    .head_data(head_e),
    .next_data(next_e),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      req_q <= req_n;
      if (state == READ && fire) rdata_q <= dcresp.data;
    end
  end

  always_comb begin
    state_n = state;
    req_n   = req_q;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_n = WDRAIN;
          req_n   = wr_req(head_e);
        end else if (push) begin
          // empty buffer: issue the incoming store straight away
          state_n = WDRAIN;
          req_n   = wr_req(in_e);
        end else if (dreq.valid && !is_wr) begin
          state_n = READ;
          req_n   = rd_req(dreq);
        end
      end
      WDRAIN: begin
        if (fire) begin
          if (|count[PW:1] || push) begin
            req_n = wr_req(next_e);
          end else begin
            state_n = IDLE;
            req_n   = '0;
          end
        end
      end
      READ: begin
        if (fire) begin
          state_n = (REG_READ_DATA != 0) ? RESP : IDLE;
          req_n   = '0;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    dresp = '0;
    if (push) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
    end
    if (REG_READ_DATA == 0 && state == READ && fire) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = dcresp.data;
    end
    if (state == RESP) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = rdata_q;
    end
  end

  assign dcreq    = req_q;
  assign wb_empty = empty & (state != WDRAIN);
  assign wb_count = count;

endmodule

// File: doc/dbus_to_cbus_wb.md
Name: dbus_to_cbus_wb

Overview:
- Next-generation DBus-to-CBus bridge with a parametrised posted write buffer.
- Stores complete in 0 cycles while the buffer has room; the buffer then drains to CBus in FIFO order.
- Loads are issued only after the buffer is empty, so CBus sees requests in program order.
- CBus request fields are registered, which removes the combinational dreq-to-dcreq path. Sits between the core DBus port and the CBus arbiter/memory side.

Parameters:
- DEPTH, 4, write-buffer entries; power of two, minimum 2.
- REG_READ_DATA, 0, 1 = read data registered and returned one cycle after CBus completion.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dreq  in  dbus_req_t  core data request: valid, addr, size, strobe, data.
- dresp  out  dbus_resp_t  addr_ok, data_ok, data.
- dcreq  out  cbus_req_t  CBus request.
- dcresp  in  cbus_resp_t  ready, last, data.
- wb_empty  out  1  buffer holds no entries and no write is in flight (used by fence).
- wb_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values:
  - head, tail, count = 0; state = IDLE.
  - dcreq.valid = 0; all other dcreq fields = 0.
  - dresp = 0; wb_empty = 1; wb_count = 0.
- Request classification: write iff |dreq.strobe; otherwise read. Core holds dreq stable until data_ok.
- Write accept:
  - Condition: dreq.valid & write & count != DEPTH.
  - In that cycle, combinationally: addr_ok = data_ok = 1.
  - On the clock edge the entry {addr, size, strobe, data} is stored at tail and tail wraps mod DEPTH.
  - When full, addr_ok = data_ok = 0 and the core stalls.
  - A dequeue in the same cycle does NOT free a slot for a same-cycle enqueue: the full test uses pre-edge count.
- FSM states: IDLE, WDRAIN, READ, RESP (RESP exists only if REG_READ_DATA = 1).
- IDLE:
  - count > 0 → WDRAIN. Register the head entry into dcreq: valid = 1, is_write = 1, len = MLEN1, burst = AXI_BURST_FIXED.
  - Else if dreq.valid & read → READ. Register dcreq with is_write = 0, strobe = 0, data = 0.
  - Writes have priority: a pending read waits for a full drain.
- WDRAIN:
  - dcreq is held constant until dcresp.ready & dcresp.last; at that edge pop head and count--.
  - If count-1 > 0 (allowing for a same-cycle enqueue), load the next head and stay in WDRAIN. Else → IDLE with dcreq.valid = 0.
  - Back-to-back entries are issued with no idle cycle.
- READ:
  - REG_READ_DATA = 0: on dcresp.ready & last, addr_ok = data_ok = 1 and data = dcresp.data (combinational); next state IDLE, dcreq.valid = 0.
  - REG_READ_DATA = 1: capture data at that edge → RESP. RESP asserts addr_ok = data_ok = 1 with the registered data for exactly one cycle → IDLE.
- Minimum read latency (empty buffer), request cycle to data_ok: 1 + CBus latency (+1 if REG_READ_DATA).
- wb_empty = (count == 0) & state != WDRAIN.
- Counters: count is updated with separate inc/dec; simultaneous enqueue and dequeue leave it unchanged. Pointers are $clog2(DEPTH) bits with natural wrap.
- A dreq.valid read arriving while state = WDRAIN gets no addr_ok until the drain finishes and the read is served.
- Reset mid-burst or mid-drain discards all buffered writes and returns to IDLE next cycle. The CBus side shares the same reset.

Decomposition:
- Shared package (common): dbus_req_t, dbus_resp_t, cbus_req_t, cbus_resp_t, MLEN1, AXI_BURST_FIXED.
- New typedef wb_entry_t {addr, size, strobe, data}, also placed in the shared package.
- Sub-module wb_fifo: parametrised DEPTH circular FIFO with push, pop, full, empty and count outputs, and head data.

Test Plan:
- Single store, strobe = 8'hFF, addr = 0x8000_0000, empty buffer → data_ok same cycle. Next cycle dcreq.valid = 1, is_write = 1 with that addr/data. wb_empty = 1 after ready & last.
- 5 stores, DEPTH = 4, CBus ready held 0 → first 4 get data_ok. 5th stalls (addr_ok = 0) until first completion, then is accepted the cycle after count drops.
- Store to 0x100 then load from 0x100 → load issued on CBus only after the write's ready & last. CBus order is write then read; load returns the model-memory value written.
- Load with empty buffer, CBus 1-cycle ready, REG_READ_DATA = 0 → data_ok 2 cycles after dreq. With REG_READ_DATA = 1 → 3 cycles, data equal to dcresp.data.
- Enqueue coincident with final dequeue (count = 1) → count stays 1. WDRAIN continues with the new entry, with no dcreq.valid gap.
- Assert reset while WDRAIN holds 3 entries → next cycle dcreq.valid = 0, wb_count = 0, wb_empty = 1, state IDLE. No stale write is issued afterward.
